// File: rtl/effect_noise_gate.sv
// effect_noise_gate: peak-envelope noise gate with hysteresis and attack/hold/release gain ramp.
// Define NOISE_GATE_STATUS_EN to expose o_gate_open and o_env status outputs.
module effect_noise_gate #(
    parameter int HOLD_SAMPLES = 2400,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 1,
    parameter int DECAY_SHIFT  = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [2:0]         i_level,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic               o_valid
`ifdef NOISE_GATE_STATUS_EN
    ,
    output logic               o_gate_open,
    output logic [14:0]        o_env
`endif
);
    typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} state_t;
    state_t             state, state_n;
    logic [14:0]        env, env_n, mag, t_open, t_close;
    logic [15:0]        neg, hold_cnt, hold_n;
    logic [8:0]         gain, gain_n;
    logic [9:0]         gain_up;
    logic signed [24:0] prod;

    // negating -32768 wraps back to 0x8000, so that case saturates to full scale
    assign neg     = -i_data;
    assign mag     = i_data[15] ? (neg[15] ? 15'h7fff : neg[14:0]) : i_data[14:0];
    assign env_n   = (mag > env) ? mag : env - (env >> DECAY_SHIFT);
    assign t_open  = (i_level == 3'd7) ? 15'd4096 : (i_level == 3'd6) ? 15'd3072 : 15'd64 << i_level;
    assign t_close = t_open - (t_open >> 2);
    assign gain_up = {1'b0, gain} + 10'(ATTACK_STEP);
    assign prod    = $signed({{9{i_data[15]}}, i_data}) * $signed({16'd0, gain});

    always_comb begin
        state_n = state;
        gain_n  = gain;
        hold_n  = hold_cnt;
        case (state)
            CLOSED: state_n = (env_n >= t_open) ? ATTACK : CLOSED;
            ATTACK: begin
                gain_n  = (gain_up >= 10'd256) ? 9'd256 : gain_up[8:0];
                state_n = (gain_n == 9'd256) ? OPEN : (env_n < t_close) ? RELEASE : ATTACK;
            end
            OPEN: begin
                state_n = (env_n < t_close) ? HOLD : OPEN;
                hold_n  = (env_n < t_close) ? 16'(HOLD_SAMPLES - 1) : hold_cnt;
            end
            HOLD: begin
                state_n = (env_n >= t_open) ? OPEN : (hold_cnt == 16'd0) ? RELEASE : HOLD;
                hold_n  = (env_n < t_open && hold_cnt != 16'd0) ? hold_cnt - 16'd1 : hold_cnt;
            end
            RELEASE: begin
                gain_n  = (gain > 9'(RELEASE_STEP)) ? gain - 9'(RELEASE_STEP) : 9'd0;
                state_n = (env_n >= t_open) ? ATTACK : (gain_n == 9'd0) ? CLOSED : RELEASE;
            end
            default: state_n = CLOSED;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= CLOSED;
            gain     <= 9'd0;
            env      <= 15'd0;
            hold_cnt <= 16'd0;
            o_data   <= 16'sd0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                state    <= state_n;
                gain     <= gain_n;
                env      <= env_n;
                hold_cnt <= hold_n;
                o_data   <= i_enable ? prod[23:8] : i_data;
            end
        end
    end

`ifdef NOISE_GATE_STATUS_EN
    assign o_env = env;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_gate_open <= 1'b0;
        else if (i_valid)
            o_gate_open <= (state_n == OPEN) || (state_n == HOLD);
    end
`endif
endmodule

// File: tb/tb_effect_noise_gate.sv
// tb_effect_noise_gate: vector table plus reference-model scoreboard for effect_noise_gate.
module tb_effect_noise_gate;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid = 1'b0;
    logic               enable = 1'b1;
    logic [2:0]         level = 3'd0;
    logic signed [15:0] data = 16'sd0;
    logic signed [15:0] o_data;
    logic               o_valid;
`ifdef NOISE_GATE_STATUS_EN
    logic               o_gate_open;
    logic [14:0]        o_env;
`endif

    effect_noise_gate #(.HOLD_SAMPLES(4)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_valid(valid),
        .i_enable(enable),
        .i_level(level),
        .i_data(data),
        .o_data(o_data),
        .o_valid(o_valid)
`ifdef NOISE_GATE_STATUS_EN
        ,
        .o_gate_open(o_gate_open),
        .o_env(o_env)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int lvl;
        int d;
        int exp;
    } vec_t;

    vec_t tbl[$];
    int   q[$];
    int   n_vec = 0, n_err = 0;
    int   last_out = 0;
    bit   chk_hold = 1'b0;
    bit   v_s;
    int   m_st = 0, m_gain = 0, m_env = 0, m_hold = 0;
    int   topen_tab[8] = '{64, 128, 256, 512, 1024, 2048, 3072, 4096};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // states: 0 closed, 1 attack, 2 open, 3 hold, 4 release
    task automatic model_step(input bit en, input int lvl, input int d, output int out);
        int a, tov, tcl;
        a = (d < 0) ? -d : d;
        if (a > 32767) a = 32767;
        m_env = (a > m_env) ? a : m_env - m_env / 64;
        tov = topen_tab[lvl];
        tcl = tov * 3 / 4;
        out = en ? ((d * m_gain) >>> 8) : d;
        case (m_st)
            0: if (m_env >= tov) m_st = 1;
            1: begin
                m_gain = (m_gain + 32 > 256) ? 256 : m_gain + 32;
                if (m_gain == 256) m_st = 2;
                else if (m_env < tcl) m_st = 4;
            end
            2: if (m_env < tcl) begin m_st = 3; m_hold = 3; end
            3: begin
                if (m_env >= tov) m_st = 2;
                else if (m_hold == 0) m_st = 4;
                else m_hold--;
            end
            default: begin
                m_gain = (m_gain > 0) ? m_gain - 1 : 0;
                if (m_env >= tov) m_st = 1;
                else if (m_gain == 0) m_st = 0;
            end
        endcase
    endtask

    task automatic send(input bit en, input int lvl, input int d, input bit use_exp, input int exp, input int gap);
        int mo;
        @(negedge clk);
        enable = en;
        level  = 3'(lvl);
        data   = 16'(d);
        valid  = 1'b1;
        model_step(en, lvl, d, mo);
        q.push_back(use_exp ? exp : mo);
        @(negedge clk);
        valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_o_data", o_data, 0);
        chk("rst_o_valid", o_valid, 0);
`ifdef NOISE_GATE_STATUS_EN
        chk("rst_o_env", o_env, 0);
        chk("rst_o_gate_open", o_gate_open, 0);
`endif
        q.delete();
        last_out = 0;
        m_st = 0; m_gain = 0; m_env = 0; m_hold = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        v_s = valid;
        #1;
        if (v_s || o_valid) chk("o_valid", o_valid, v_s);
        if (o_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL o_data_unexpected: got %0d with no sample pending", o_data);
            end else begin
                chk("o_data", o_data, q.pop_front());
                last_out = o_data;
            end
        end else if (chk_hold) begin
            chk("o_data_hold", o_data, last_out);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pat[5] = '{-32768, 12345, -7, 0, 32767};
        for (int i = 0; i < 10; i++) tbl.push_back(vec_t'{1'b1, 3, 100, 0});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 0});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 0});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 1250});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 2500});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 3750});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 5000});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 6250});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 7500});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 8750});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 10000});
        tbl.push_back(vec_t'{1'b1, 0, 10000, 10000});
        tbl.push_back(vec_t'{1'b1, 0, -32768, -32768});
        tbl.push_back(vec_t'{1'b0, 0, 1234, 1234});

        repeat (2) @(negedge clk);
        do_reset();
        foreach (tbl[i]) send(tbl[i].en, tbl[i].lvl, tbl[i].d, 1'b1, tbl[i].exp, 0);

        // silence at level 2 until the release ramp is halfway down
        for (int i = 0; i < 3000; i++) begin
            if (m_st == 4 && m_gain == 128) break;
            send(1'b1, 2, 0, 1'b0, 0, 0);
        end
        if (!(m_st == 4 && m_gain == 128)) begin
            n_vec++;
            n_err++;
            $display("FAIL release_reach: state %0d gain %0d, expected release at gain 128", m_st, m_gain);
        end

        send(1'b1, 2, 30000, 1'b1, 15000, 0);
        send(1'b1, 2, 30000, 1'b1, 14882, 0);
        send(1'b1, 2, 30000, 1'b1, 18632, 0);

        @(negedge clk);
        do_reset();
        send(1'b1, 3, 100, 1'b1, 0, 0);
        send(1'b0, 3, -32768, 1'b1, -32768, 0);
        repeat (3) send(1'b0, 3, -32768, 1'b0, 0, 0);
        repeat (12) send(1'b1, 0, 5000, 1'b0, 0, 0);

        chk_hold = 1'b1;
        foreach (pat[i]) send(1'b1, 0, pat[i], 1'b0, 0, 5);
        chk_hold = 1'b0;

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d samples never produced, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
